// File: rtl/pam_sequencer.sv
// Control sequencer for the pipelined adding machine: issues a window of
// consecutive operand indices, tracks them through fetch/add, and gates the accumulator.
module pam_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] base,
    input  logic [5:0] len,
    input  logic       hold,
    output logic [4:0] index,
    output logic       rd_en,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] remaining;
    logic [5:0] len_sat;
    logic       v1, v2;

    assign len_sat = (len > 6'd32) ? 6'd32 : len;
    assign acc_en  = v2 & ~hold;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        acc_clr = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    acc_clr = 1'b1;
                    state_d = (len == 6'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                rd_en = ~hold;
                if (!hold && remaining == 6'd1)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // v1 empty means the coming advance leaves both stages empty
                if (!hold && !v1)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            index     <= '0;
            remaining <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
                if (start) begin
                    index     <= base;
                    remaining <= len_sat;
                end
            end else if (!hold) begin
                v1 <= rd_en;
                v2 <= v1;
                if (state_q == S_RUN) begin
                    index     <= index + 5'd1;
                    remaining <= remaining - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pam_sequencer.sv
// Directed self-checking bench for pam_sequencer; expected values are hand-derived
// cycle schedules relative to the start-accept cycle T.
module tb_pam_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] base;
    logic [5:0] len;
    logic       hold;
    logic [4:0] index;
    logic       rd_en;
    logic       acc_clr;
    logic       acc_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pam_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .base   (base),
        .len    (len),
        .hold   (hold),
        .index  (index),
        .rd_en  (rd_en),
        .acc_clr(acc_clr),
        .acc_en (acc_en),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [11:0] hold_v, rd_v, acc_v, done_v;
    logic [4:0]  wrap_idx [4];
    int          rd_cnt, acc_cnt, done_cnt, exp_idx;
    bit          seen;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        hold  = 1'b0;

        // reset then idle
        repeat (6) tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_rd_en", rd_en, 0);
            chk("idle_acc_en", acc_en, 0);
            chk("idle_done", done, 0);
            chk("idle_index", index, 0);
            tick();
        end

        // base=3 len=4, no hold
        start = 1'b1; base = 5'd3; len = 6'd4;
        #1;
        chk("b3_acc_clr_T", acc_clr, 1);
        chk("b3_busy_T", busy, 0);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("b3_rd_en", rd_en, (k <= 4));
            if (k <= 4) chk("b3_index", index, 3 + k - 1);
            chk("b3_acc_en", acc_en, (k >= 3 && k <= 6));
            chk("b3_done", done, (k == 7));
            chk("b3_busy", busy, (k <= 7));
            chk("b3_acc_clr", acc_clr, 0);
            tick();
        end

        // wrap: base=30 len=4
        wrap_idx = '{5'd30, 5'd31, 5'd0, 5'd1};
        start = 1'b1; base = 5'd30; len = 6'd4;
        tick();
        start = 1'b0;
        acc_cnt = 0; rd_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (rd_en) begin
                if (rd_cnt < 4) chk("wrap_index", index, wrap_idx[rd_cnt]);
                rd_cnt++;
            end
            if (acc_en) acc_cnt++;
            chk("wrap_done", done, (k == 7));
            tick();
        end
        chk("wrap_rd_count", rd_cnt, 4);
        chk("wrap_acc_count", acc_cnt, 4);

        // base=0 len=5, hold on cycles 3,4 (after second issue) and 8 (in DRAIN)
        hold_v = 12'h118;
        rd_v   = 12'h0E6;
        acc_v  = 12'h6E0;
        done_v = 12'h800;
        start = 1'b1; base = 5'd0; len = 6'd5;
        tick();
        start = 1'b0;
        exp_idx = 0;
        for (int k = 1; k <= 12; k++) begin
            hold = (k <= 11) ? hold_v[k] : 1'b0;
            #1;
            if (k <= 11) begin
                chk("hold_rd_en", rd_en, rd_v[k]);
                chk("hold_acc_en", acc_en, acc_v[k]);
                chk("hold_done", done, done_v[k]);
                chk("hold_busy", busy, 1);
                if (rd_v[k]) begin
                    chk("hold_index", index, exp_idx);
                    exp_idx++;
                end
            end else begin
                chk("hold_idle_after", busy, 0);
            end
            tick();
        end
        hold = 1'b0;

        // len=0
        start = 1'b1; base = 5'd9; len = 6'd0;
        #1;
        chk("len0_acc_clr", acc_clr, 1);
        tick();
        start = 1'b0;
        #1;
        chk("len0_busy_T1", busy, 1);
        chk("len0_done_T1", done, 1);
        chk("len0_rd_en_T1", rd_en, 0);
        chk("len0_acc_en_T1", acc_en, 0);
        tick();
        #1;
        chk("len0_busy_T2", busy, 0);
        chk("len0_done_T2", done, 0);
        tick();

        // len=40 saturates to 32
        start = 1'b1; base = 5'd4; len = 6'd40;
        tick();
        start = 1'b0;
        rd_cnt = 0; acc_cnt = 0; seen = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            #1;
            if (rd_en) begin
                if (rd_cnt == 31) chk("len40_last_index", index, 3);
                rd_cnt++;
            end
            if (acc_en) acc_cnt++;
            if (done) begin
                seen = 1'b1;
                chk("len40_done_cycle", k, 35);
            end
            tick();
        end
        chk("len40_done_seen", seen, 1);
        chk("len40_rd_count", rd_cnt, 32);
        chk("len40_acc_count", acc_cnt, 32);

        // start during RUN is ignored
        start = 1'b1; base = 5'd10; len = 6'd6;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) begin
                start = 1'b1; base = 5'd20; len = 6'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (k == 2) chk("busy_start_acc_clr", acc_clr, 0);
            chk("busy_start_rd_en", rd_en, (k <= 6));
            if (k <= 6) chk("busy_start_index", index, 10 + k - 1);
            chk("busy_start_done", done, (k == 9));
            tick();
        end

        // reset mid-run, then immediate restart
        start = 1'b1; base = 5'd5; len = 6'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1; base = 5'd7; len = 6'd2;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_done", done, 0);
        chk("rst_index", index, 0);
        chk("rst_restart_acc_clr", acc_clr, 1);
        tick();
        start = 1'b0;
        #1;
        chk("rst_restart_rd_en", rd_en, 1);
        chk("rst_restart_index", index, 7);
        tick();
        done_cnt = 0;
        for (int k = 2; k <= 7; k++) begin
            #1;
            if (done) done_cnt++;
            chk("rst_restart_done", done, (k == 5));
            tick();
        end
        chk("rst_restart_done_count", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
